// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, host-burst and memory-macro signals of the data memory arbiter.
interface dmem_arbiter_if #(parameter int AW = 8, parameter int DW = 8);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          host_start;
    logic          host_wr;
    logic [AW-1:0] host_base;
    logic [AW-1:0] host_len;
    logic [DW-1:0] host_wdata;
    logic          host_wready;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid;
    logic          host_busy;
    logic          host_done;
    logic          host_starved;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, host_start, host_wr, host_base, host_len,
               host_wdata, mem_rdata,
        output cpu_rdata, host_wready, host_rdata, host_rvalid, host_busy, host_done,
               host_starved, mem_addr, mem_we, mem_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, host_start, host_wr, host_base, host_len,
               host_wdata, mem_rdata,
        input  cpu_rdata, host_wready, host_rdata, host_rvalid, host_busy, host_done,
               host_starved, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the scp core (always wins) and a host burst port.
// Define DMEM_ARB_STARVE_EN to build the blocked-cycle counter and sticky host_starved flag.
module dmem_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 15
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    state_t        state;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] cnt_q;
    logic          wr_q;
    logic          hostBeat;
    logic          startOk;

    assign hostBeat        = state == XFER && !bus.cpu_req;
    assign startOk         = state == IDLE && bus.host_start;
    assign bus.mem_addr    = hostBeat ? addr_q : bus.cpu_addr;
    assign bus.mem_we      = bus.cpu_req ? bus.cpu_we : hostBeat && wr_q;
    assign bus.mem_wdata   = hostBeat ? bus.host_wdata : bus.cpu_wdata;
    assign bus.host_wready = hostBeat && wr_q;
    assign bus.cpu_rdata   = bus.mem_rdata;
    assign bus.host_busy   = state != IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            addr_q          <= '0;
            cnt_q           <= '0;
            wr_q            <= 1'b0;
            bus.host_rdata  <= DW'(0);
            bus.host_rvalid <= 1'b0;
            bus.host_done   <= 1'b0;
        end else begin
            bus.host_rvalid <= hostBeat && !wr_q;
            bus.host_done   <= hostBeat && cnt_q == '0;
            if (startOk) begin
                addr_q <= bus.host_base;
                cnt_q  <= bus.host_len;
                wr_q   <= bus.host_wr;
                state  <= XFER;
            end else if (state == DONE) begin
                state <= IDLE;
            end else if (hostBeat) begin
                addr_q <= addr_q + AW'(1);
                if (!wr_q) bus.host_rdata <= bus.mem_rdata;
                if (cnt_q == '0) state <= DONE;
                else cnt_q <= cnt_q - AW'(1);
            end
        end
    end

`ifdef DMEM_ARB_STARVE_EN
    logic [7:0] blockCnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blockCnt         <= 8'd0;
            bus.host_starved <= 1'b0;
        end else if (startOk) begin
            blockCnt         <= 8'd0;
            bus.host_starved <= 1'b0;
        end else if (state == XFER && bus.cpu_req) begin
            if (blockCnt != 8'(MAX_WAIT)) blockCnt <= blockCnt + 8'd1;
            if (blockCnt == 8'(MAX_WAIT - 1)) bus.host_starved <= 1'b1;
        end else if (hostBeat) begin
            blockCnt <= 8'd0;
        end
    end
`else
    // MAX_WAIT is confined to 1..255, so this ties the flag low
    assign bus.host_starved = MAX_WAIT == 0;
`endif
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 8-bit data memory between the scp core and a host burst-transfer port (loader/debug DMA). The core has no stall input, so it owns every cycle it requests; host beats are slotted into the cycles the core leaves free. Sits between scp (toDataMemoryAddress/toDataMemory/memWrite/fromDataMemory) and the data memory macro.

## Interface

- AW, 8, address width
- DW, 8, data width
- MAX_WAIT, 15, consecutive blocked host cycles before starvation flag (1..255)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  core accesses memory this cycle (load or store)
- cpu_we  in  1  core write strobe (memWrite)
- cpu_addr  in  AW  core address (toDataMemoryAddress)
- cpu_wdata  in  DW  core write data (toDataMemory)
- cpu_rdata  out  DW  read data to core (fromDataMemory), combinational
- host_start  in  1  one-cycle burst start pulse
- host_wr  in  1  burst direction, 1 = write memory
- host_base  in  AW  burst start address
- host_len  in  AW  beats minus one (0 = 1 beat, 255 = 256 beats)
- host_wdata  in  DW  write data, held until consumed
- host_wready  out  1  write beat consumed this cycle
- host_rdata  out  DW  registered read data
- host_rvalid  out  1  host_rdata valid, one-cycle pulse per beat
- host_busy  out  1  burst in progress
- host_done  out  1  one-cycle completion pulse
- host_starved  out  1  sticky starvation flag
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, asynchronous read

## Operation

- States: IDLE, XFER, DONE. Reset -> IDLE.
- IDLE: host_start latches host_base -> addr_q, host_len -> cnt_q, host_wr -> wr_q; next XFER. host_start ignored in XFER/DONE.
- Grant (combinational): cpu_req=1 -> core owns memory: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata. Core always wins.
- Host beat: state XFER and cpu_req=0 -> mem_addr=addr_q, mem_we=wr_q, mem_wdata=host_wdata; host_wready=wr_q.
- No owner: mem_addr=cpu_addr, mem_we=0, mem_wdata=cpu_wdata.
- cpu_rdata = mem_rdata always.
- Per beat at clock edge: addr_q+1 (mod 2^AW, 0xFF wraps to 0x00); read beat captures mem_rdata -> host_rdata, host_rvalid=1 next cycle. If cnt_q==0 -> DONE, else cnt_q-1.
- DONE: host_done=1 for one cycle -> IDLE.
- host_busy = (state != IDLE).
- Blocked counter: in XFER, cpu_req=1 increments (saturating at MAX_WAIT); any beat clears it. Reaching MAX_WAIT sets host_starved; cleared only by accepted host_start or reset.

## Timing

- Reset values: state IDLE, addr_q 0, cnt_q 0, host_rdata 0x00, host_rvalid 0, host_done 0, host_starved 0, host_busy 0, host_wready 0, mem_we 0.
- host_start at edge N -> XFER from N; first beat earliest cycle N+1 (cycle after the pulse).
- Unblocked burst of L+1 beats: beats cycles 1..L+1 after start, host_done in cycle L+2, host_busy low from L+3.
- Read latency: host_rvalid one cycle after its beat.
- Core access never delayed; same-cycle combinational path cpu_addr -> mem_addr -> mem_rdata -> cpu_rdata.
- host_start in the DONE cycle is ignored.
- Reset mid-burst: burst aborted, no host_done, no further beats; memory contents already written remain.

## Configuration

- DMEM_ARB_STARVE_EN defined: blocked counter and host_starved implemented as above.
- Undefined: counter removed, host_starved tied 0; MAX_WAIT unused.

## Test plan

- Write burst: base 0x10, len 3, wdata 0xA0..0xA3, cpu_req=0 -> mem writes 0x10..0x13 on 4 consecutive cycles, host_done in cycle 5, host_busy low cycle 6.
- Read burst interleaved: base 0x20, len 1, cpu_req=1 on first XFER cycle -> core gets mem_addr=cpu_addr that cycle, host beats at 0x20 then 0x21 one cycle late, host_rvalid each one cycle after beat.
- Wrap: base 0xFE, len 3 -> beat addresses 0xFE, 0xFF, 0x00, 0x01.
- Starvation: cpu_req held 1 for 15 cycles in XFER -> host_starved=1 at 15th cycle, stays 1 after burst; next host_start clears it (macro undefined: always 0).
- Reset mid-burst: rst low during beat 2 of 5 -> all outputs at reset values, no host_done; host_start while busy ignored (cnt_q, addr_q unchanged).
